// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_gen: parametrised raster timing (pixel enable, H/V counters,  |
// | sync, blanking, line/frame markers) with an optional sync/blank delay line.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_timing_gen #(
  parameter int CLK_MHZ    = 50,
  parameter int PIXEL_MHZ  = 25,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int SYNC_DELAY = 0,
  parameter int W_X        = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  parameter int W_Y        = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           o_pixel_en,
  output logic [W_X-1:0] o_x,
  output logic [W_Y-1:0] o_y,
  output logic           o_display_on,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_line_start,
  output logic           o_frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_CLK_DIV = CLK_MHZ / PIXEL_MHZ;
  localparam int c_W_DIV   = (c_CLK_DIV > 1) ? $clog2(c_CLK_DIV) : 1;

  localparam logic [c_W_DIV-1:0] c_DIV_LAST = c_W_DIV'(c_CLK_DIV - 1);
  localparam logic [W_X-1:0] c_X_LAST  = W_X'(c_H_TOTAL - 1);
  localparam logic [W_X-1:0] c_H_ACT   = W_X'(H_ACTIVE);
  localparam logic [W_X-1:0] c_HS_BEG  = W_X'(H_ACTIVE + H_FRONT);
  localparam logic [W_X-1:0] c_HS_END  = W_X'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [W_Y-1:0] c_Y_LAST  = W_Y'(c_V_TOTAL - 1);
  localparam logic [W_Y-1:0] c_V_ACT   = W_Y'(V_ACTIVE);
  localparam logic [W_Y-1:0] c_VS_BEG  = W_Y'(V_ACTIVE + V_FRONT);
  localparam logic [W_Y-1:0] c_VS_END  = W_Y'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  // Delay-line word is {display_on, hsync, vsync}; idle = blanked, syncs deasserted.
  localparam logic [2:0] c_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

  if (PIXEL_MHZ < 1 || CLK_MHZ < PIXEL_MHZ || (CLK_MHZ % PIXEL_MHZ) != 0) begin : g_bad_clk_div
    $error("video_timing_gen: CLK_MHZ / PIXEL_MHZ must be an integer >= 1");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_sync_delay
    $error("video_timing_gen: SYNC_DELAY must be in 0..15");
  end

  logic [c_W_DIV-1:0] r_div;
  logic               r_pixel_en;
  logic [W_X-1:0]     r_x;
  logic [W_Y-1:0]     r_y;
  logic               r_line_start;
  logic               r_frame_start;
  logic [2:0]         r_pipe [SYNC_DELAY+1];

  logic           w_tick;
  logic           w_x_wrap;
  logic [W_X-1:0] w_x_next;
  logic [W_Y-1:0] w_y_next;
  logic [2:0]     w_dec;

  // w_tick marks the edge at which pixel_en rises, so counters move in that same cycle.
  assign w_tick   = (r_div == c_DIV_LAST);
  assign w_x_wrap = (r_x == c_X_LAST);

  always_comb begin
    w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
    end
    w_dec[2] = (w_x_next < c_H_ACT) && (w_y_next < c_V_ACT);
    w_dec[1] = ((w_x_next >= c_HS_BEG) && (w_x_next <= c_HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    w_dec[0] = ((w_y_next >= c_VS_BEG) && (w_y_next <= c_VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pixel_en    <= 1'b0;
      r_x           <= c_X_LAST;
      r_y           <= c_Y_LAST;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      r_pixel_en    <= w_tick;
      r_line_start  <= w_tick && w_x_wrap;
      r_frame_start <= w_tick && w_x_wrap && (r_y == c_Y_LAST);
      if (w_tick) begin
        r_x <= w_x_next;
        r_y <= w_y_next;
      end
    end
  end

  // Stage 0 holds the undelayed decode; stage SYNC_DELAY drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        r_pipe[i] <= c_IDLE;
      end
    end else if (w_tick) begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_pixel_en    = r_pixel_en;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_display_on  = r_pipe[SYNC_DELAY][2];
  assign o_hsync       = r_pipe[SYNC_DELAY][1];
  assign o_vsync       = r_pipe[SYNC_DELAY][0];

endmodule
`default_nettype wire
